// File: rtl/obi_sram_responder.sv
// OBI slave front-end for a single-port SRAM macro with in-order responses and credit flow control.
// Define OBI_SRAM_RESP_ERR_EN to return error responses for addresses beyond the SRAM.
module obi_sram_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned RESP_DEPTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [31:0]               obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [3:0]                obi_be_i,
  input  logic [31:0]               obi_wdata_i,
  output logic                      obi_rvalid_o,
  input  logic                      obi_rready_i,
  output logic [31:0]               obi_rdata_o,
  output logic                      obi_err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(RESP_DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RESP_DEPTH - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_rdata_q [RESP_DEPTH];
  logic            fifo_err_q   [RESP_DEPTH];

  logic pipe_valid_q, pipe_valid_d;
  logic pipe_we_q, pipe_we_d;
  logic pipe_err_q, pipe_err_d;

  logic        addr_err;
  logic        gnt;
  logic        fifo_empty;
  logic        rvalid;
  logic        retire;
  logic        push;
  logic        pop;
  logic [31:0] pipe_rdata;
  logic        unused_addr;

`ifdef OBI_SRAM_RESP_ERR_EN
  assign addr_err    = |obi_addr_i[31:MEM_ADDR_WIDTH+2];
  assign unused_addr = ^obi_addr_i[1:0];
`else
  // Upper address bits alias onto the SRAM.
  assign addr_err    = 1'b0;
  assign unused_addr = ^{obi_addr_i[31:MEM_ADDR_WIDTH+2], obi_addr_i[1:0]};
`endif

  assign fifo_empty = (fifo_cnt_q == '0);
  assign rvalid     = !fifo_empty || pipe_valid_q;
  assign retire     = rvalid && obi_rready_i;
  assign pop        = !fifo_empty && obi_rready_i;
  // The pipeline entry bypasses the FIFO only when it is the response being retired now.
  assign push       = pipe_valid_q && !(fifo_empty && obi_rready_i);

  // A retire this cycle frees a credit for the same-cycle grant.
  assign gnt = !rst_i && obi_req_i && ((cnt_q < DepthCnt) || retire);

  assign obi_gnt_o   = gnt;
  assign mem_req_o   = gnt && !addr_err;
  assign mem_we_o    = obi_we_i;
  assign mem_addr_o  = obi_addr_i[MEM_ADDR_WIDTH+1:2];
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  assign pipe_rdata = (pipe_valid_q && !pipe_we_q && !pipe_err_q) ? mem_rdata_i : 32'h0;

  assign obi_rvalid_o = rvalid;

  always_comb begin
    obi_rdata_o = pipe_rdata;
    obi_err_o   = pipe_valid_q && pipe_err_q;
    if (!fifo_empty) begin
      obi_rdata_o = fifo_rdata_q[rd_ptr_q];
      obi_err_o   = fifo_err_q[rd_ptr_q];
    end
  end

  always_comb begin
    pipe_valid_d = gnt;
    pipe_we_d    = gnt && obi_we_i;
    pipe_err_d   = gnt && addr_err;

    cnt_d      = cnt_q + CntW'(gnt) - CntW'(retire);
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pipe_valid_q <= 1'b0;
      pipe_we_q    <= 1'b0;
      pipe_err_q   <= 1'b0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
        fifo_rdata_q[i] <= 32'h0;
        fifo_err_q[i]   <= 1'b0;
      end
    end else begin
      cnt_q        <= cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_we_q    <= pipe_we_d;
      pipe_err_q   <= pipe_err_d;
      if (push) begin
        // mem_rdata_i is only valid now, so the read data is captured on push.
        fifo_rdata_q[wr_ptr_q] <= pipe_rdata;
        fifo_err_q[wr_ptr_q]   <= pipe_err_q;
      end
    end
  end

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench for obi_sram_responder: SRAM model, shadow memory and in-order response scoreboard.
// Follows OBI_SRAM_RESP_ERR_EN to choose error-response or aliasing expectations.
module tb_obi_sram_responder;

  localparam int unsigned MemAw = 10;
  localparam int unsigned Depth = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             obi_req_i = 1'b0;
  logic             obi_gnt_o;
  logic [31:0]      obi_addr_i = '0;
  logic             obi_we_i = 1'b0;
  logic [3:0]       obi_be_i = 4'hF;
  logic [31:0]      obi_wdata_i = '0;
  logic             obi_rvalid_o;
  logic             obi_rready_i = 1'b1;
  logic [31:0]      obi_rdata_o;
  logic             obi_err_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [MemAw-1:0] mem_addr_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_q = '0;

  int checks = 0;
  int errors = 0;

  obi_sram_responder #(
    .MEM_ADDR_WIDTH (MemAw),
    .RESP_DEPTH     (Depth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_q)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];

  // SRAM macro: read data valid one cycle after the strobe.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_q <= sram[mem_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
`ifdef OBI_SRAM_RESP_ERR_EN
    return |a[31:MemAw+2];
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard entries are {err, rdata}.
  logic [32:0] exp_q [$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      logic [32:0] e;
      logic        ae;
      logic [MemAw-1:0] idx;
      chk("fifo_no_overflow", 32'(int'(dut.fifo_cnt_q) <= Depth), 32'd1);
      if (hold_v) begin
        chk("hold_rvalid", 32'(obi_rvalid_o), 32'd1);
        chk("hold_rdata", obi_rdata_o, hold_rdata);
        chk("hold_err", 32'(obi_err_o), 32'(hold_err));
      end
      hold_v     = obi_rvalid_o && !obi_rready_i;
      hold_rdata = obi_rdata_o;
      hold_err   = obi_err_o;
      if (obi_rvalid_o && obi_rready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", obi_rdata_o, e[31:0]);
          chk("rsp_err", 32'(obi_err_o), 32'(e[32]));
        end
      end
      if (obi_req_i && obi_gnt_o) begin
        ae  = is_err(obi_addr_i);
        idx = obi_addr_i[MemAw+1:2];
        chk("mem_req", 32'(mem_req_o), 32'(!ae));
        if (!ae) chk("mem_addr", 32'(mem_addr_o), 32'(idx));
        if (ae) begin
          exp_q.push_back({1'b1, 32'h0});
        end else if (obi_we_i) begin
          for (int b = 0; b < 4; b++) begin
            if (obi_be_i[b]) ref_mem[idx][8*b +: 8] = obi_wdata_i[8*b +: 8];
          end
          exp_q.push_back({1'b0, 32'h0});
        end else begin
          exp_q.push_back({1'b0, ref_mem[idx]});
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output int waited);
    obi_req_i   = 1'b1;
    obi_addr_i  = a;
    obi_we_i    = we;
    obi_be_i    = be;
    obi_wdata_i = wd;
    waited      = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (obi_gnt_o) break;
      waited++;
    end
    if (waited >= 50) chk("gnt_timeout", 32'(waited), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    obi_req_i = 1'b0;
    obi_we_i  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = sram[i];
    end
    sram[16]    = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    // Reset state with a request pending.
    obi_req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", 32'(obi_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_err", 32'(obi_err_o), 32'd0);
    chk("rst_rdata", obi_rdata_o, 32'h0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();

    // Single read.
    issue(32'h40, 1'b0, 4'hF, 32'h0, w);
    chk("single_gnt_wait", 32'(w), 32'd0);
    idle();
    @(negedge clk_i);
    chk("single_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("single_rdata", obi_rdata_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    chk("single_cnt", 32'(dut.cnt_q), 32'd0);

    // Back-to-back write then read.
    issue(32'h8, 1'b1, 4'hF, 32'h1122_3344, w);
    issue(32'h8, 1'b0, 4'hF, 32'h0, w);
    chk("b2b_gnt_wait", 32'(w), 32'd0);
    idle();
    drain();

    // Partial byte-enable write and readback.
    issue(32'h8, 1'b1, 4'h5, 32'hAABB_CCDD, w);
    issue(32'h8, 1'b0, 4'hF, 32'h0, w);
    idle();
    drain();

    // Backpressure: two credits, third stalls until the first retire.
    obi_rready_i = 1'b0;
    issue(32'h0, 1'b0, 4'hF, 32'h0, w);
    issue(32'h4, 1'b0, 4'hF, 32'h0, w);
    chk("bp_second_wait", 32'(w), 32'd0);
    obi_req_i  = 1'b1;
    obi_addr_i = 32'h8;
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_stall_gnt", 32'(obi_gnt_o), 32'd0);
    end
    chk("bp_cnt_full", 32'(dut.cnt_q), 32'(Depth));
    @(posedge clk_i);
    #1;
    obi_rready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_gnt_on_retire", 32'(obi_gnt_o), 32'd1);
    chk("bp_rvalid_on_retire", 32'(obi_rvalid_o), 32'd1);
    @(posedge clk_i);
    #1;
    idle();
    drain();

    // Out-of-range address: error response or alias of word 0.
    issue(32'h0001_0000, 1'b0, 4'hF, 32'h0, w);
    idle();
    drain();

    // Reset mid-flight discards pending responses.
    obi_rready_i = 1'b0;
    issue(32'h10, 1'b0, 4'hF, 32'h0, w);
    issue(32'h14, 1'b0, 4'hF, 32'h0, w);
    idle();
    rst_i     = 1'b1;
    obi_req_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_gnt", 32'(obi_gnt_o), 32'd0);
    chk("mid_rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();
    repeat (2) begin
      @(negedge clk_i);
      chk("post_rst_rvalid", 32'(obi_rvalid_o), 32'd0);
      chk("post_rst_cnt", 32'(dut.cnt_q), 32'd0);
    end
    @(posedge clk_i);
    #1;
    obi_rready_i = 1'b1;
    issue(32'h40, 1'b0, 4'hF, 32'h0, w);
    chk("post_rst_gnt_wait", 32'(w), 32'd0);
    idle();
    drain();
    repeat (2) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_sram_responder.md
OBI_SRAM_RESPONDER -- requirements
Module: obi_sram_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, word-address width of the attached SRAM macro (1024 x 32-bit words).
REQ-002 SHALL have parameter RESP_DEPTH, default 2, maximum outstanding granted-but-unretired transactions (legal range 1..4).
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
REQ-004 SHALL have the OBI slave side:
- obi_req_i     in   1   request
- obi_gnt_o     out  1   grant
- obi_addr_i    in   32  byte address
- obi_we_i      in   1   write enable
- obi_be_i      in   4   byte enables
- obi_wdata_i   in   32  write data
- obi_rvalid_o  out  1   response valid
- obi_rready_i  in   1   response ready
- obi_rdata_o   out  32  read data
- obi_err_o     out  1   response error
REQ-005 SHALL have the SRAM side:
- mem_req_o    out  1               access strobe
- mem_we_o     out  1               write
- mem_addr_o   out  MEM_ADDR_WIDTH  word address
- mem_be_o     out  4               byte enables
- mem_wdata_o  out  32              write data
- mem_rdata_i  in   32              read data, valid exactly 1 cycle after mem_req_o

Function
REQ-006 SHALL keep counter cnt (0..RESP_DEPTH) = transactions granted and not yet retired by obi_rvalid_o && obi_rready_i.
REQ-007 SHALL drive obi_gnt_o = obi_req_i && (cnt < RESP_DEPTH || retire this cycle), combinationally.
REQ-008 On grant with a valid address, SHALL assert mem_req_o in the same cycle, with mem_addr_o = obi_addr_i[MEM_ADDR_WIDTH+1:2] and mem_we_o/mem_be_o/mem_wdata_o passed through.
REQ-009 SHALL hold mem_req_o low in every cycle without a grant.
REQ-010 SHALL register per grant a pipeline entry {valid, we, err}; in the following cycle the response is either presented or pushed into a RESP_DEPTH-entry response FIFO.
REQ-011 obi_rvalid_o SHALL be FIFO-not-empty OR pipeline-valid; earliest response one cycle after grant.
REQ-012 Response source:
- FIFO non-empty: obi_rdata_o/obi_err_o from FIFO head.
- FIFO empty: from the pipeline entry, with rdata = mem_rdata_i.
REQ-013 Write responses and error responses SHALL carry obi_rdata_o = 0.
REQ-014 A pipeline entry SHALL bypass the FIFO only when the FIFO is empty and obi_rready_i is high; otherwise it SHALL be pushed.
REQ-015 Responses SHALL retire in grant order.
REQ-016 The FIFO SHALL never overflow; the credit in REQ-007 guarantees this, and the bench SHALL assert it.
REQ-017 Simultaneous grant and retire SHALL leave cnt unchanged.
REQ-018 obi_rdata_o/obi_err_o SHALL be stable while obi_rvalid_o && !obi_rready_i.
REQ-019 FIFO pointers SHALL wrap modulo RESP_DEPTH.

Reset
REQ-020 While rst_i is high:
- cnt = 0, FIFO empty, pipeline invalid
- obi_gnt_o = 0, obi_rvalid_o = 0, mem_req_o = 0, obi_err_o = 0, obi_rdata_o = 0
REQ-021 Reset asserted mid-transaction SHALL discard all pending responses; no response for them SHALL appear after reset release.

Configuration
REQ-022 Macro OBI_SRAM_RESP_ERR_EN, when defined:
- obi_addr_i[31:MEM_ADDR_WIDTH+2] nonzero -> granted normally, mem_req_o held low, response returned with obi_err_o = 1 and rdata 0.
REQ-023 When OBI_SRAM_RESP_ERR_EN is undefined:
- obi_err_o SHALL be tied 0 and upper address bits ignored (aliasing).

Verification
REQ-024 Single read: SRAM word 0x10 = 0xDEADBEEF, req addr 0x40, rready=1 -> gnt same cycle, mem_addr_o=0x10, rvalid next cycle with rdata 0xDEADBEEF, cnt back to 0.
REQ-025 Back-to-back traffic: write 0x11223344 to 0x8 with be=0xF, then read 0x8, rready=1 -> two grants in consecutive cycles; write response rdata 0, read response 0x11223344, in order.
REQ-026 Backpressure: rready=0, req held with reads of 0x0, 0x4, 0x8 -> exactly 2 grants, third stalls; raise rready -> third granted in the same cycle as the first retire; responses arrive in order.
REQ-027 Error (macro defined): read 0x0001_0000 -> mem_req_o stays 0, rvalid with err=1 and rdata 0; macro undefined -> reads alias word 0x000.
REQ-028 Reset mid-flight: grant 2 reads with rready=0, pulse rst_i for 1 cycle -> rvalid=0 after reset, cnt=0, next request granted immediately.
